mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline latch of the 5-stage MIPS pipeline.
- Sits directly downstream of the EX/MEM latch and consumes its registered outputs.
- Drives the data-cache request and holds it until dhit. Resolves writeback data by MemtoReg, registers the writeback controls for the register file, and stalls the pipeline while a data access is outstanding.

Parameters:
- CNT_W, 32, width of the memory-stall performance counter.

Ports:
- CLK  input  1  pipeline clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- ihit  input  1  instruction-side hit; the pipeline may advance only when set
- dhit  input  1  data cache completed the current dmemREN/dmemWEN access
- dmemload  input  32  load data from the data cache, valid when dhit=1
- flush  input  1  squash: the latch loads a bubble on the next advance
- dREN_in  input  1  load in stage, from the EX/MEM latch
- dWEN_in  input  1  store in stage, from the EX/MEM latch
- portO_in  input  32  ALU result: memory address or writeback value
- dmemStore_in  input  32  store data
- LUI_in  input  32  upper-immediate value
- pcp4_in  input  32  PC+4, the JAL link value
- MemtoReg_in  input  2  writeback select
- WSel_in  input  5  destination register
- WEN_in  input  1  register write enable
- dmemREN  output  1  data read request
- dmemWEN  output  1  data write request
- dmemaddr  output  32  data address (= portO_in)
- dmemstore  output  32  store data (= dmemStore_in)
- mem_stall  output  1  access outstanding; upstream latches must hold
- advance  output  1  the stage latches this cycle (ihit & ~mem_stall)
- WEN_wb  output  1  registered register-file write enable
- WSel_wb  output  5  registered destination register
- wdat_wb  output  32  registered writeback data, also the WB forwarding source
- stall_cnt  output  CNT_W  count of cycles with mem_stall=1

Behaviour:
- Writeback select from MemtoReg: 00 → portO_in, 01 → load data, 10 → LUI_in, 11 → pcp4_in.
- mem_op = dREN_in | dWEN_in.
- FSM states:
  - M_ACCESS: access not yet completed.
  - M_DONE: access completed, waiting for the pipeline to advance.
- Reset: state=M_ACCESS; WEN_wb=0, WSel_wb=0, wdat_wb=0, stall_cnt=0, ld_hold=0.
- Requests (combinational):
  - dmemREN = dREN_in & (state==M_ACCESS); dmemWEN = dWEN_in & (state==M_ACCESS).
  - Both are 0 in M_DONE, so an access is never reissued.
- mem_stall = mem_op & (state==M_ACCESS) & ~dhit. advance = ihit & ~mem_stall.
- Load data = dmemload when state==M_ACCESS, otherwise ld_hold.
- State transitions:
  - M_ACCESS → M_DONE when mem_op & dhit & ~advance; capture ld_hold ← dmemload in the same cycle.
  - M_DONE → M_ACCESS on advance.
  - M_ACCESS stays in M_ACCESS on advance.
  - All other cases hold state.
- Latch update:
  - On advance & ~flush: WEN_wb←WEN_in, WSel_wb←WSel_in, wdat_wb←selected data.
  - On advance & flush: bubble, i.e. all three ← 0.
  - Without advance: hold. A flush asserted without advance is ignored; upstream keeps it asserted until ihit.
- Latency: non-memory instruction in 1 cycle. Memory instruction in 1 cycle after the cycle in which both dhit and ihit have been seen.
- Simultaneous dhit & ihit in M_ACCESS: latch directly from dmemload; state stays M_ACCESS.
- dhit while ~mem_op: ignored.
- Store: dmemWEN held until dhit; the writeback value is portO_in (WEN_in is 0 from decode).
- stall_cnt increments each cycle mem_stall=1 and saturates at all-ones.
- RST mid-access: state→M_ACCESS and the latch clears on the next edge. Requests reflect the inputs combinationally; the upstream latch is also reset.

Decomposition:
- cpu_types_pkg holds word_t, regbits_t, and a new enum memstate_t {M_ACCESS, M_DONE}.
- Add localparams for the MemtoReg encodings: WB_ALU=2'b00, WB_MEM=2'b01, WB_LUI=2'b10, WB_PC4=2'b11.
- The writeback mux is a natural sub-module, wb_select (pure combinational). The FSM and latch remain in mem_wb_stage.

Test Plan:
- Reset test: RST=1 for 2 cycles → WEN_wb=0, wdat_wb=0, stall_cnt=0, dmemREN=0 with inputs idle.
- ALU op: MemtoReg=00, portO_in=0x1234, WSel=5, WEN=1, ihit=1 → next cycle WEN_wb=1, WSel_wb=5, wdat_wb=0x1234, mem_stall never set.
- Load with 3-cycle miss: dREN_in=1, portO_in=0x100, ihit=1, dhit=0 for 3 cycles, then dmemload=0xDEADBEEF with dhit=1 → mem_stall=1 for 3 cycles, dmemaddr=0x100, wdat_wb=0xDEADBEEF next edge, stall_cnt=3.
- dhit before ihit: load, dhit=1 with dmemload=0xCAFEF00D, ihit=0 for 2 further cycles, dmemload then changed to 0 → dmemREN=0 in M_DONE; on ihit, wdat_wb=0xCAFEF00D.
- Flush on advance: JAL with MemtoReg=11, pcp4=0x44, flush=1, ihit=1 → WEN_wb=0, WSel_wb=0, wdat_wb=0. Same with ihit=0 → latch holds its previous values.
- Store plus reset mid-miss: dWEN_in=1, dmemStore_in=0xAA, dhit=0, RST pulsed on the 2nd cycle → after reset state=M_ACCESS, stall_cnt=0, latch cleared, dmemWEN follows dWEN_in.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the 5-stage MIPS core.
// Memory-stage state and writeback-select encodings live here too.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic {
        M_ACCESS = 1'b0,
        M_DONE   = 1'b1
    } memstate_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_LUI = 2'b10;
    localparam logic [1:0] WB_PC4 = 2'b11;

endpackage

// File: rtl/wb_select.sv
// Writeback data mux driven by MemtoReg.
// Purely combinational; feeds the MEM/WB latch.
module wb_select
    import cpu_types_pkg::*;
(
    input  logic [1:0] memtoReg,
    input  word_t      aluRes,
    input  word_t      loadData,
    input  word_t      luiVal,
    input  word_t      pcp4,
    output word_t      wdat
);

    always_comb begin
        wdat = aluRes;
        unique case (memtoReg)
            WB_ALU: wdat = aluRes;
            WB_MEM: wdat = loadData;
            WB_LUI: wdat = luiVal;
            WB_PC4: wdat = pcp4;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB latch: issues the data-cache access,
// stalls until dhit and registers the writeback controls.
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  word_t            dmemload,
    input  logic             flush,
    input  logic             dREN_in,
    input  logic             dWEN_in,
    input  word_t            portO_in,
    input  word_t            dmemStore_in,
    input  word_t            LUI_in,
    input  word_t            pcp4_in,
    input  logic [1:0]       MemtoReg_in,
    input  regbits_t         WSel_in,
    input  logic             WEN_in,
    output logic             dmemREN,
    output logic             dmemWEN,
    output word_t            dmemaddr,
    output word_t            dmemstore,
    output logic             mem_stall,
    output logic             advance,
    output logic             WEN_wb,
    output regbits_t         WSel_wb,
    output word_t            wdat_wb,
    output logic [CNT_W-1:0] stall_cnt
);

    memstate_t state;
    word_t     ldHold;
    word_t     loadData;
    word_t     wdatSel;
    logic      memOp;
    logic      inAccess;

    assign memOp     = dREN_in | dWEN_in;
    assign inAccess  = (state == M_ACCESS);
    assign dmemREN   = dREN_in & inAccess;
    assign dmemWEN   = dWEN_in & inAccess;
    assign dmemaddr  = portO_in;
    assign dmemstore = dmemStore_in;
    assign mem_stall = memOp & inAccess & ~dhit;
    assign advance   = ihit & ~mem_stall;

    // Once captured, the load word must survive dmemload changing.
    assign loadData = inAccess ? dmemload : ldHold;

    wb_select uSel (
        .memtoReg (MemtoReg_in),
        .aluRes   (portO_in),
        .loadData (loadData),
        .luiVal   (LUI_in),
        .pcp4     (pcp4_in),
        .wdat     (wdatSel)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= M_ACCESS;
            ldHold    <= '0;
            WEN_wb    <= 1'b0;
            WSel_wb   <= '0;
            wdat_wb   <= '0;
            stall_cnt <= '0;
        end else begin
            if (mem_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;

            unique case (state)
                M_ACCESS: begin
                    if (memOp && dhit && !advance) begin
                        state  <= M_DONE;
                        ldHold <= dmemload;
                    end
                end
                M_DONE: begin
                    if (advance)
                        state <= M_ACCESS;
                end
            endcase

            if (advance) begin
                if (flush) begin
                    WEN_wb  <= 1'b0;
                    WSel_wb <= '0;
                    wdat_wb <= '0;
                end else begin
                    WEN_wb  <= WEN_in;
                    WSel_wb <= WSel_in;
                    wdat_wb <= wdatSel;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against a
// cycle-level reference model of the memory stage.
module tb_mem_wb_stage;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST, ihit, dhit, flush;
    logic [31:0]   dmemload, portO_in, dmemStore_in, LUI_in, pcp4_in;
    logic          dREN_in, dWEN_in, WEN_in;
    logic [1:0]    MemtoReg_in;
    logic [4:0]    WSel_in;
    logic          dmemREN, dmemWEN, mem_stall, advance, WEN_wb;
    logic [31:0]   dmemaddr, dmemstore, wdat_wb;
    logic [4:0]    WSel_wb;
    logic [CW-1:0] stall_cnt;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: has the outstanding access already been served?
    bit          mServed;
    logic [31:0] mHeld;
    logic        mWen;
    logic [4:0]  mWsel;
    logic [31:0] mWdat;
    int          mCnt;

    mem_wb_stage #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemload(dmemload), .flush(flush),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .portO_in(portO_in), .dmemStore_in(dmemStore_in),
        .LUI_in(LUI_in), .pcp4_in(pcp4_in),
        .MemtoReg_in(MemtoReg_in), .WSel_in(WSel_in), .WEN_in(WEN_in),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .advance(advance),
        .WEN_wb(WEN_wb), .WSel_wb(WSel_wb), .wdat_wb(wdat_wb),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RST = 0; ihit = 0; dhit = 0; flush = 0; dmemload = '0;
        dREN_in = 0; dWEN_in = 0; portO_in = '0; dmemStore_in = '0;
        LUI_in = '0; pcp4_in = '0; MemtoReg_in = 2'b00;
        WSel_in = '0; WEN_in = 0;
    endtask

    // One clock: check request/stall outputs, clock, check latch.
    task automatic step(input bit checkComb, output bit expAdv);
        bit          memOp, expStall;
        logic [31:0] ld, sel;
        #1;
        memOp    = dREN_in | dWEN_in;
        expStall = memOp && !mServed && !dhit;
        expAdv   = ihit && !expStall;
        if (checkComb) begin
            chk("dmemREN", dmemREN, dREN_in && !mServed);
            chk("dmemWEN", dmemWEN, dWEN_in && !mServed);
            chk("mem_stall", mem_stall, expStall);
            chk("advance", advance, expAdv);
            chk("dmemaddr", dmemaddr, portO_in);
            chk("dmemstore", dmemstore, dmemStore_in);
        end
        ld = mServed ? mHeld : dmemload;
        case (MemtoReg_in)
            2'b00:   sel = portO_in;
            2'b01:   sel = ld;
            2'b10:   sel = LUI_in;
            default: sel = pcp4_in;
        endcase
        @(posedge CLK);
        if (RST) begin
            mServed = 0; mHeld = '0; mWen = 0; mWsel = '0;
            mWdat = '0; mCnt = 0;
        end else begin
            if (expStall && mCnt < (1 << CW) - 1) mCnt++;
            if (expAdv) begin
                mWen  = flush ? 1'b0 : WEN_in;
                mWsel = flush ? 5'd0 : WSel_in;
                mWdat = flush ? 32'd0 : sel;
            end
            if (!mServed && memOp && dhit && !expAdv) begin
                mServed = 1;
                mHeld   = dmemload;
            end else if (mServed && expAdv) begin
                mServed = 0;
            end
        end
        #1;
        chk("WEN_wb", WEN_wb, mWen);
        chk("WSel_wb", WSel_wb, mWsel);
        chk("wdat_wb", wdat_wb, mWdat);
        chk("stall_cnt", stall_cnt, mCnt);
    endtask

    initial begin
        bit adv;
        bit lastAdv;
        mServed = 0; mHeld = '0; mWen = 0; mWsel = '0;
        mWdat = '0; mCnt = 0;
        idle();

        // Reset
        RST = 1;
        step(0, adv);
        step(1, adv);
        chk("rst_wen", WEN_wb, 0);
        chk("rst_wdat", wdat_wb, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_ren", dmemREN, 0);

        // ALU op
        idle();
        portO_in = 32'h1234; WSel_in = 5; WEN_in = 1; ihit = 1;
        step(1, adv);
        chk("alu_wen", WEN_wb, 1);
        chk("alu_wsel", WSel_wb, 5);
        chk("alu_wdat", wdat_wb, 32'h1234);
        chk("alu_stall", mem_stall, 0);

        // Load, 3-cycle miss
        idle();
        dREN_in = 1; portO_in = 32'h100; ihit = 1;
        MemtoReg_in = 2'b01; WSel_in = 7; WEN_in = 1;
        for (int i = 0; i < 3; i++) begin
            step(1, adv);
            chk("miss_stall", mem_stall, 1);
            chk("miss_addr", dmemaddr, 32'h100);
        end
        dhit = 1; dmemload = 32'hDEADBEEF;
        step(1, adv);
        chk("miss_wdat", wdat_wb, 32'hDEADBEEF);
        chk("miss_cnt", stall_cnt, 3);

        // dhit before ihit
        idle();
        dREN_in = 1; MemtoReg_in = 2'b01; WSel_in = 3; WEN_in = 1;
        dhit = 1; dmemload = 32'hCAFEF00D;
        step(1, adv);
        dhit = 0; dmemload = '0;
        for (int i = 0; i < 2; i++) begin
            step(1, adv);
            chk("done_ren", dmemREN, 0);
            chk("done_stall", mem_stall, 0);
        end
        ihit = 1;
        step(1, adv);
        chk("early_wdat", wdat_wb, 32'hCAFEF00D);
        chk("early_cnt", stall_cnt, 3);

        // Flush without advance holds, with advance bubbles
        idle();
        portO_in = 32'h55; WSel_in = 9; WEN_in = 1; ihit = 1;
        step(1, adv);
        idle();
        MemtoReg_in = 2'b11; pcp4_in = 32'h44; WSel_in = 31;
        WEN_in = 1; flush = 1;
        step(1, adv);
        chk("flush_hold_wdat", wdat_wb, 32'h55);
        chk("flush_hold_wsel", WSel_wb, 9);
        ihit = 1;
        step(1, adv);
        chk("flush_wen", WEN_wb, 0);
        chk("flush_wsel", WSel_wb, 0);
        chk("flush_wdat", wdat_wb, 0);

        // Store with reset mid-miss
        idle();
        dWEN_in = 1; dmemStore_in = 32'hAA; portO_in = 32'h200; ihit = 1;
        step(1, adv);
        chk("st_wen", dmemWEN, 1);
        chk("st_data", dmemstore, 32'hAA);
        RST = 1;
        step(1, adv);
        chk("st_rst_cnt", stall_cnt, 0);
        chk("st_rst_wdat", wdat_wb, 0);
        RST = 0;
        step(1, adv);
        chk("st_again", dmemWEN, 1);
        dhit = 1;
        step(1, adv);

        // Randomized traffic; instruction fields change only on advance
        lastAdv = 1;
        for (int i = 0; i < 600; i++) begin
            if (lastAdv) begin
                logic [1:0] kind;
                kind        = 2'($urandom_range(0, 3));
                dREN_in     = (kind == 1);
                dWEN_in     = (kind == 2);
                portO_in    = $urandom;
                dmemStore_in = $urandom;
                LUI_in      = $urandom;
                pcp4_in     = $urandom;
                MemtoReg_in = dREN_in ? 2'b01 : 2'($urandom_range(0, 3));
                if (dWEN_in && MemtoReg_in == 2'b01) MemtoReg_in = 2'b00;
                WSel_in     = 5'($urandom);
                WEN_in      = !dWEN_in && $urandom_range(0, 3) != 0;
                flush       = ($urandom_range(0, 9) == 0);
            end
            ihit     = ($urandom_range(0, 9) < 6);
            dhit     = ($urandom_range(0, 9) < 3);
            dmemload = $urandom;
            RST      = ($urandom_range(0, 79) == 0);
            step(1, adv);
            lastAdv = adv || RST;
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
